// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract unit.
// Operands are latched on an accepted start and processed one bit per clock,
// LSB first, through a single full adder. Subtraction reuses the adder as
// a + ~b + 1 by inverting b and presetting the carry to 1.
// Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
// DONE); busy stays high for exactly WIDTH cycles, then done pulses for one
// cycle with result/ovf valid, and those outputs hold until the next accepted
// start.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             mode_r;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             accept;
    logic             last_bit;
    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             carry_out;

    // A new operation is taken only when no operation is in flight.
    assign accept   = (state != RUN) && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // One full-adder slice on the current bit; b is inverted for subtract.
    always_comb begin
        bit_a     = a_r[cnt];
        bit_b     = b_r[cnt] ^ mode_r;
        sum_bit   = bit_a ^ bit_b ^ carry;
        carry_out = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture and serial accumulation of result, carry and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            cnt    <= '0;
            carry  <= mode;
            result <= '0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            result[cnt] <= sum_bit;
            carry       <= carry_out;
            cnt         <= cnt + 1'b1;
            if (last_bit) begin
                // Subtract reports the borrow, i.e. the inverted carry.
                result[WIDTH] <= carry_out ^ mode_r;
                // Signed overflow: carry into the MSB differs from carry out.
                ovf           <= carry ^ carry_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=4): directed scenarios plus random
// operations, checked against an integer-arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W:0]   result;
    logic         ovf;

    int checks;
    int failures;

    // Scoreboard entries are {ovf, result}.
    logic [W+1:0] exp_q[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic m);
        int ux, uy, sx, sy, ur, sr;
        logic [W:0] r;
        logic o;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        ur = m ? ux - uy : ux + uy;
        r  = ur[W:0];
        sr = m ? sx - sy : sx + sy;
        o  = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
        return {o, r};
    endfunction

    // Driver: called right after a falling edge; returns right after the
    // falling edge that follows the done edge. With noise=1 the inputs are
    // scrambled and start is pulsed while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tm, input bit noise);
        logic [W+1:0] exp;
        exp_q.push_back(ref_model(ta, tb_v, tm));
        a     = ta;
        b     = tb_v;
        mode  = tm;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL run_status cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         i, busy, done);
            end
            if (noise) begin
                a     = W'($urandom);
                b     = W'($urandom);
                mode  = 1'($urandom);
                start = (i == W-1) ? 1'b0 : ((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: busy=%b done=%b, required busy=0 done=1", busy, done);
        end
        checks++;
        if ({ovf, result} !== exp) begin
            failures++;
            $display("FAIL result a=%b b=%b mode=%b: ovf=%b result=%b, required ovf=%b result=%b",
                     ta, tb_v, tm, ovf, result, exp[W+1], exp[W:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        checks++;
        if ({busy, done, ovf, result} !== '0) begin
            failures++;
            $display("FAIL reset_async: busy=%b done=%b ovf=%b result=%b, required all 0",
                     busy, done, ovf, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, ovf, result} !== '0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b ovf=%b result=%b, required all 0",
                     busy, done, ovf, result);
        end
    endtask

    task automatic test_add();
        run_op(4'b0110, 4'b1010, 1'b0, 0);
        checks++;
        if (result !== 5'b10000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_0110_1010: result=%b ovf=%b, required 10000 0", result, ovf);
        end
        // Hold after done: result stays, done drops.
        @(negedge clk);
        checks++;
        if (result !== 5'b10000 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_hold: result=%b done=%b busy=%b, required 10000 0 0",
                     result, done, busy);
        end
        run_op(4'b1110, 4'b1101, 1'b0, 0);
        checks++;
        if (result !== 5'b11011 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_1110_1101: result=%b ovf=%b, required 11011 0", result, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_sub();
        run_op(4'b0110, 4'b1010, 1'b1, 0);
        checks++;
        if (result !== 5'b11100) begin
            failures++;
            $display("FAIL sub_0110_1010: result=%b, required 11100", result);
        end
        @(negedge clk);
        run_op(4'b1110, 4'b1101, 1'b1, 0);
        checks++;
        if (result !== 5'b00001 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_1110_1101: result=%b ovf=%b, required 00001 0", result, ovf);
        end
        @(negedge clk);
        run_op(4'b0000, 4'b0011, 1'b1, 0);
        checks++;
        if (result !== 5'b11101 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_0000_0011: result=%b ovf=%b, required 11101 0", result, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_ovf();
        run_op(4'b0111, 4'b0001, 1'b0, 0);
        checks++;
        if (result !== 5'b01000 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_add_0111_0001: result=%b ovf=%b, required 01000 1", result, ovf);
        end
        @(negedge clk);
        run_op(4'b1000, 4'b0001, 1'b1, 0);
        checks++;
        if (result !== 5'b00111 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sub_1000_0001: result=%b ovf=%b, required 00111 1", result, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        run_op(4'b0101, 4'b0011, 1'b0, 1);
        checks++;
        if (result !== 5'b01000) begin
            failures++;
            $display("FAIL ignore_start: result=%b, required 01000", result);
        end
        @(negedge clk);
        run_op(4'b0010, 4'b0111, 1'b1, 1);
        @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        a     = 4'b0011;
        b     = 4'b0000;
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Second RUN cycle: bit 0 of the result is already 1.
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, result} !== '0) begin
            failures++;
            $display("FAIL reset_in_run: busy=%b done=%b ovf=%b result=%b, required all 0",
                     busy, done, ovf, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < W + 1; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done cycle %0d: busy=%b done=%b, required 0 0",
                         i, busy, done);
            end
            @(negedge clk);
        end
        // Start together with reset release: first edge must accept it.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0010, 4'b0001, 1'b0, 0);
        checks++;
        if (result !== 5'b00011) begin
            failures++;
            $display("FAIL post_reset_add: result=%b, required 00011", result);
        end
        @(negedge clk);
    endtask

    // Chained calls drive start in the DONE cycle, so there is no IDLE gap.
    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_ignore_start();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
